// File: rtl/cr_axi4s_mstr_arb_if.sv
// AXI4-S word/ready types and the source-to-master bus of cr_axi4s_mstr_arb.
// master modport is the arbiter side; slave is the FIFO/downstream side.
package cr_axi4s_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_su_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

interface cr_axi4s_mstr_arb_if #(
  parameter int N_SRC = 4
);
  import cr_axi4s_pkg::*;

  axi4s_su_dp_bus_t [N_SRC-1:0] axi4s_in;
  logic [N_SRC-1:0]             axi4s_in_empty;
  logic [N_SRC-1:0]             axi4s_in_aempty;
  logic [N_SRC-1:0]             axi4s_mstr_rd;
  axi4s_dp_rdy_t                axi4s_ob_in;
  axi4s_su_dp_bus_t             axi4s_ob_out;

  modport master (
    input  axi4s_in,
    input  axi4s_in_empty,
    input  axi4s_in_aempty,
    input  axi4s_ob_in,
    output axi4s_mstr_rd,
    output axi4s_ob_out
  );

  modport slave (
    output axi4s_in,
    output axi4s_in_empty,
    output axi4s_in_aempty,
    output axi4s_ob_in,
    input  axi4s_mstr_rd,
    input  axi4s_ob_out
  );

endinterface

// File: rtl/cr_axi4s_mstr_arb.sv
// Packet-granular round-robin arbiter onto one registered AXI4-S stage.
// Optional per-source packet counters: define CR_AXI4S_ARB_STATS_EN.
module cr_axi4s_mstr_arb
  import cr_axi4s_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cr_axi4s_mstr_arb_if.master    bus,
  output logic [ID_W-1:0]        arb_grant_id,
  output logic                   arb_busy
`ifdef CR_AXI4S_ARB_STATS_EN
  ,
  output logic [N_SRC-1:0][31:0] arb_pkt_cnt
`endif
);

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_grant;
  logic [ID_W-1:0]  r_last;
  axi4s_su_dp_bus_t r_ob;

  logic             w_found;
  logic [ID_W-1:0]  w_next;
  logic [ID_W-1:0]  w_cand;
  logic             w_rd;
  logic             w_eop;
  axi4s_su_dp_bus_t w_head;
  logic             w_unused_aempty;

  assign w_unused_aempty = ^bus.axi4s_in_aempty;

  // First non-empty source strictly after the last grant, wrapping at N_SRC.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_cand = ID_W'((int'(r_last) + k) % N_SRC);
      if (!w_found && !bus.axi4s_in_empty[w_cand]) begin
        w_found = 1'b1;
        w_next  = w_cand;
      end
    end
  end

  assign w_head = bus.axi4s_in[r_grant];

  assign w_rd = (r_state == S_LOCK)
              & ~bus.axi4s_in_empty[r_grant]
              & (~r_ob.tvalid | bus.axi4s_ob_in.tready);

  assign w_eop = w_rd & w_head.tlast;

  always_comb begin
    bus.axi4s_mstr_rd          = '0;
    bus.axi4s_mstr_rd[r_grant] = w_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= ID_W'(N_SRC - 1);
      r_ob    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_LOCK;
            r_grant <= w_next;
            r_last  <= w_next;
          end
        end
        S_LOCK: begin
          if (w_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_rd) begin
        r_ob <= w_head;
      end else if (r_ob.tvalid && bus.axi4s_ob_in.tready) begin
        r_ob <= '0;
      end
    end
  end

  assign bus.axi4s_ob_out = r_ob;
  assign arb_grant_id     = r_grant;
  assign arb_busy         = (r_state == S_LOCK);

`ifdef CR_AXI4S_ARB_STATS_EN
  logic [N_SRC-1:0][31:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_eop) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
    end
  end

  assign arb_pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_cr_axi4s_mstr_arb.sv
// Bench for cr_axi4s_mstr_arb: queue-based source FIFOs and an RR packet model.
// Directed contention/backpressure/underrun/reset cases plus random rounds.
module tb_cr_axi4s_mstr_arb;
  import cr_axi4s_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cr_axi4s_mstr_arb_if #(.N_SRC(N)) bus ();
  logic [IW-1:0] gnt;
  logic          busy;
`ifdef CR_AXI4S_ARB_STATS_EN
  logic [N-1:0][31:0] pkt_cnt;
`endif

  cr_axi4s_mstr_arb #(
    .N_SRC(N),
    .ID_W (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .arb_grant_id(gnt),
    .arb_busy    (busy)
`ifdef CR_AXI4S_ARB_STATS_EN
    ,
    .arb_pkt_cnt (pkt_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  axi4s_su_dp_bus_t q[N][$];
  axi4s_su_dp_bus_t exp_q[$];
  axi4s_su_dp_bus_t out_q[$];
  int               out_cyc[$];
  logic [N-1:0]     hold = '0;
  logic             rdy  = 1'b1;
  int               m_last = N - 1;
  axi4s_su_dp_bus_t prev_ob = '0;
  logic             prev_rdy = 1'b1;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.axi4s_in_empty[i] = (q[i].size() == 0) || hold[i];
      bus.axi4s_in[i]       = (q[i].size() != 0) ? q[i][0] : '0;
    end
    bus.axi4s_in_aempty    = '0;
    bus.axi4s_ob_in.tready = rdy;
  endtask

  task automatic tick();
    logic [N-1:0]     rd_s;
    logic [N-1:0]     emp_s;
    axi4s_su_dp_bus_t ob_s;
    logic             rdy_s;
    @(negedge clk);
    rd_s  = bus.axi4s_mstr_rd;
    emp_s = bus.axi4s_in_empty;
    ob_s  = bus.axi4s_ob_out;
    rdy_s = rdy;
    if (rst_n) begin
      chk("rd_onehot", 128'($countones(rd_s) <= 1), 128'(1));
      chk("rd_on_empty", 128'(rd_s & emp_s), 128'(0));
      if (ob_s.tvalid && !rdy_s)
        chk("pop_in_stall", 128'(rd_s), 128'(0));
      if (prev_ob.tvalid && !prev_rdy)
        chk("stall_hold", 128'(ob_s), 128'(prev_ob));
    end
    prev_ob  = ob_s;
    prev_rdy = rdy_s;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (rd_s[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (ob_s.tvalid && rdy_s) begin
      out_q.push_back(ob_s);
      out_cyc.push_back(cyc);
    end
    drive();
  endtask

  task automatic add_pkt(int src, int len);
    for (int j = 0; j < len; j++) begin
      axi4s_su_dp_bus_t w;
      w.tvalid = 1'b1;
      w.tlast  = (j == len - 1);
      w.tuser  = 8'(src * 16 + j);
      w.tdata  = {$urandom, $urandom};
      q[src].push_back(w);
    end
  endtask

  // Whole packets, one per visit, visiting sources in rotation after m_last.
  task automatic predict();
    int pos[N];
    int p;
    for (int i = 0; i < N; i++) pos[i] = 0;
    forever begin
      p = -1;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_last + k) % N;
        if (p < 0 && pos[s] < q[s].size()) p = s;
      end
      if (p < 0) break;
      m_last = p;
      do begin
        exp_q.push_back(q[p][pos[p]]);
        pos[p]++;
      end while (!q[p][pos[p]-1].tlast);
    end
  endtask

  task automatic clr();
    exp_q.delete();
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic drain(string tag, bit rand_rdy);
    int n;
    bit pend;
    n = 0;
    forever begin
      pend = busy || bus.axi4s_ob_out.tvalid;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) pend = 1'b1;
      if (!pend || n >= 3000) break;
      if (rand_rdy) rdy = ($urandom_range(3) != 0);
      drive();
      tick();
      n++;
    end
    rdy = 1'b1;
    drive();
    chk({tag, "_timeout"}, 128'(n < 3000), 128'(1));
    chk({tag, "_count"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 128'(out_q[i]), 128'(exp_q[i]));
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_rd"}, 128'(bus.axi4s_mstr_rd), 128'(0));
    chk({tag, "_tvalid"}, 128'(bus.axi4s_ob_out.tvalid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_gnt"}, 128'(gnt), 128'(0));
  endtask

  initial begin
    int c;
    int n;
    axi4s_su_dp_bus_t held;
    int sz0;
    int sz1;

    drive();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ob", 128'(bus.axi4s_ob_out), 128'(0));
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;

    // Reset idle: nothing requested for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle("idle");
    end

    // Contention: four 3-word packets, strict rotation, one bubble between.
    for (int s = 0; s < N; s++) add_pkt(s, 3);
    predict();
    drive();
    c = cyc;
    tick();
    chk("cont_gnt", 128'(gnt), 128'(0));
    chk("cont_busy", 128'(busy), 128'(1));
    drain("cont", 1'b0);
    chk("cont_ncyc", 128'(out_cyc.size()), 128'(12));
    if (out_cyc.size() == 12)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 3; j++)
          chk("cont_time", 128'(out_cyc[k*3+j]), 128'(c + 3 + 4*k + j));
    clr();

    // Backpressure: tready low for 5 cycles mid-packet.
    add_pkt(0, 6);
    add_pkt(1, 2);
    predict();
    drive();
    n = 0;
    while (out_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reach", 128'(n < 50), 128'(1));
    rdy = 1'b0;
    drive();
    held = bus.axi4s_ob_out;
    sz0  = q[0].size();
    sz1  = q[1].size();
    chk("bp_valid", 128'(held.tvalid), 128'(1));
    for (int i = 0; i < 5; i++) tick();
    chk("bp_held", 128'(bus.axi4s_ob_out), 128'(held));
    chk("bp_nopop0", 128'(q[0].size()), 128'(sz0));
    chk("bp_nopop1", 128'(q[1].size()), 128'(sz1));
    rdy = 1'b1;
    drive();
    drain("bp", 1'b0);
    clr();

    // Underrun: source 2 dries up after its first word.
    add_pkt(2, 4);
    add_pkt(3, 2);
    predict();
    drive();
    n = 0;
    while (q[2].size() != 3 && n < 50) begin
      tick();
      n++;
    end
    chk("ur_reach", 128'(n < 50), 128'(1));
    hold[2] = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ur_gnt", 128'(gnt), 128'(2));
      chk("ur_busy", 128'(busy), 128'(1));
    end
    chk("ur_src3", 128'(q[3].size()), 128'(2));
    hold[2] = 1'b0;
    drive();
    drain("ur", 1'b0);
    clr();

    // Async reset with word 2 of 4 in flight from source 1.
    add_pkt(1, 4);
    drive();
    n = 0;
    while (q[1].size() != 2 && n < 50) begin
      tick();
      n++;
    end
    chk("ar_reach", 128'(n < 50), 128'(1));
    chk("ar_valid", 128'(bus.axi4s_ob_out.tvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ob", 128'(bus.axi4s_ob_out), 128'(0));
    chk_idle("ar");
    for (int i = 0; i < N; i++) q[i].delete();
    prev_ob = '0;
    m_last  = N - 1;
    clr();
    drive();
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    add_pkt(0, 2);
    add_pkt(2, 2);
    predict();
    drive();
    tick();
    chk("ar_regnt", 128'(gnt), 128'(0));
    drain("ar", 1'b0);
    clr();

    // Random rounds with random tready.
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < N; s++) begin
        int np;
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 4));
      end
      predict();
      drive();
      drain("rnd", 1'b1);
      clr();
    end

`ifdef CR_AXI4S_ARB_STATS_EN
    rst_n = 1'b0;
    m_last = N - 1;
    #1;
    for (int i = 0; i < 2; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) add_pkt(1, 1);
    predict();
    drive();
    drain("st", 1'b0);
    clr();
    for (int s = 0; s < N; s++)
      chk("st_cnt", 128'(pkt_cnt[s]), 128'((s == 1) ? 5 : 0));
    force dut.r_pkt_cnt[1] = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt[1];
    add_pkt(1, 1);
    predict();
    drive();
    drain("st_wrap", 1'b0);
    clr();
    chk("st_wrap_cnt", 128'(pkt_cnt[1]), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
